// File: rtl/srt_div_pkg.sv
// Shared types and width helpers for the radix-4 SRT divide sequencer.
package srt_div_pkg;

  localparam int DEF_WIDTH = 26;
  localparam int DEF_ITERS = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } srt_state_e;

  // Signed quotient digit, range -3..+3
  typedef logic signed [2:0] srt_digit_t;

  function automatic int rem_w(input int width);
    return width + 1;
  endfunction

  function automatic int wide_w(input int width);
    return width + 3;
  endfunction

  function automatic int quo_w(input int iters);
    return 2 * iters + 1;
  endfunction

endpackage

// File: rtl/srt_digit_select.sv
// Radix-4 digit selection: q = sign(w) * min(floor(|w|/d), 3).
module srt_digit_select
  import srt_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH+2:0] w_i,
  input  logic        [WIDTH-1:0] d_i,
  output srt_digit_t              q_o
);

  localparam int WW = wide_w(WIDTH);

  logic [WW-1:0] w_mag_s;
  logic [WW-1:0] d1_s;
  logic [WW-1:0] d2_s;
  logic [WW-1:0] d3_s;
  logic [1:0]    mag_s;
  srt_digit_t    mag_dig_s;

  // |w| never exceeds 4d, so an unsigned WW-bit magnitude is exact
  always_comb begin
    w_mag_s = w_i[WW-1] ? $unsigned(-w_i) : $unsigned(w_i);
    d1_s    = {3'b000, d_i};
    d2_s    = {2'b00, d_i, 1'b0};
    d3_s    = d1_s + d2_s;
  end

  always_comb begin
    if (w_mag_s >= d3_s) begin
      mag_s = 2'd3;
    end else if (w_mag_s >= d2_s) begin
      mag_s = 2'd2;
    end else if (w_mag_s >= d1_s) begin
      mag_s = 2'd1;
    end else begin
      mag_s = 2'd0;
    end
  end

  always_comb begin
    mag_dig_s = {1'b0, mag_s};
    q_o       = w_i[WW-1] ? -mag_dig_s : mag_dig_s;
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// Radix-4 SRT divide sequencer: operand handshake, range check, ITERS digit
// iterations and a held result on the output handshake.
module srt_div_ctrl
  import srt_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITERS = DEF_ITERS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [WIDTH:0]  dividend,
  input  logic [WIDTH-1:0]       divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [2*ITERS:0] quotient,
  output logic signed [WIDTH:0]  remainder,
  output logic                   err,
  output logic                   busy
);

  localparam int NW = rem_w(WIDTH);
  localparam int WW = wide_w(WIDTH);
  localparam int QW = quo_w(ITERS);
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  srt_state_e            state_q, state_d;
  logic signed [NW-1:0]  r_q, r_d;
  logic signed [QW-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]      d_q, d_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [NW-1:0]         n_mag_s;
  logic                  range_err_s;
  logic signed [WW-1:0]  w_s;
  srt_digit_t            dig_s;
  logic signed [NW-1:0]  prod_s;
  logic signed [NW-1:0]  r_iter_s;
  logic signed [QW-1:0]  quo_iter_s;

  always_comb begin
    n_mag_s     = dividend[WIDTH] ? $unsigned(-dividend) : $unsigned(dividend);
    range_err_s = (divisor == {WIDTH{1'b0}}) || (n_mag_s >= {1'b0, divisor});
  end

  // |r| < d keeps 4r inside WW bits and the new remainder inside NW bits
  always_comb begin
    w_s        = $signed({r_q, 2'b00});
    prod_s     = NW'(dig_s) * $signed({1'b0, d_q});
    r_iter_s   = (r_q <<< 2) - prod_s;
    quo_iter_s = (quo_q <<< 2) + QW'(dig_s);
  end

  srt_digit_select #(
    .WIDTH(WIDTH)
  ) u_digit_select (
    .w_i(w_s),
    .d_i(d_q),
    .q_o(dig_s)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    quo_d   = quo_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r_d     = dividend;
          quo_d   = {QW{1'b0}};
          d_d     = divisor;
          state_d = range_err_s ? S_DONE : S_ITER;
          err_d   = range_err_s;
          cnt_d   = CW'(ITERS - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        r_d   = r_iter_s;
        quo_d = quo_iter_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_ITER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= {NW{1'b0}};
      quo_q       <= {QW{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      quo_q       <= quo_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign quotient  = quo_q;
  assign remainder = r_q;

endmodule
